// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display path.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Scan slot index; slot N drives anode an[N]
    localparam logic [1:0] DIG_SEC_ONES   = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS   = 2'd1;
    localparam logic [1:0] DIG_SCORE_ONES = 2'd2;
    localparam logic [1:0] DIG_SCORE_TENS = 2'd3;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder (active-low segments).
// Non-BCD codes 10..15 decode to a dash so bad data is visible on the board.
module bcd_to_seg
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Digit lookup with dash fallback for invalid codes
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/timer_display.sv
// Four-digit multiplexed seven-segment driver for score and countdown timer.
// Timer-domain inputs (sec_tens, sec_ones, end_game) are synchronised and
// only captured once stable, then scanned with the score digits.
// Optional build macro: TIMER_DISPLAY_LZ_BLANK_EN blanks leading zeros on the
// score tens and timer tens digits.
module timer_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    input  logic       end_game,
    input  logic       pause,
    input  logic [3:0] score_tens,
    input  logic [3:0] score_ones,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    // Timer bundle layout: {end_game, sec_tens, sec_ones}
    logic [8:0]    r_sync1;
    logic [8:0]    r_sync2;
    logic [8:0]    r_cap;
    logic          r_end_prev;
    logic [RW-1:0] r_refresh_cnt;
    logic [1:0]    r_digit_sel;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic [3:0]    w_cap_ones;
    logic [3:0]    w_cap_tens;
    logic          w_cap_end;
    logic          w_stable;
    logic [3:0]    w_digit;
    logic [6:0]    w_dec_seg;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    assign w_cap_ones = r_cap[3:0];
    assign w_cap_tens = r_cap[7:4];
    assign w_cap_end  = r_cap[8];

    // Stage 2 is known stable when the value about to enter it matches it,
    // i.e. stage 2 holds the same word on two consecutive cycles.
    assign w_stable = (r_sync1 == r_sync2);

    // Two-flop synchroniser plus stability-gated capture of the timer word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cap   <= '0;
        end else begin
            r_sync1 <= {end_game, sec_tens, sec_ones};
            r_sync2 <= r_sync1;
            if (w_stable) begin
                r_cap <= r_sync2;
            end
        end
    end

    // Slot timer and digit selector: advance one slot every REFRESH_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= DIG_SEC_ONES;
        end else if (r_refresh_cnt == REFRESH_LAST) begin
            r_refresh_cnt <= '0;
            r_digit_sel   <= r_digit_sel + 2'd1;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + RW'(1);
        end
    end

    // Blink phase: held visible until game end, restarted visible on its rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_end_prev  <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_end_prev <= w_cap_end;
            if (!w_cap_end) begin
                r_blink_cnt <= '0;
                r_blink_on  <= 1'b1;
            end else if (!r_end_prev) begin
                r_blink_cnt <= '0;
                r_blink_on  <= 1'b1;
            end else if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Select the digit value for the active slot
    always_comb begin
        w_digit = w_cap_ones;
        case (r_digit_sel)
            DIG_SEC_ONES:   w_digit = w_cap_ones;
            DIG_SEC_TENS:   w_digit = w_cap_tens;
            DIG_SCORE_ONES: w_digit = score_ones;
            DIG_SCORE_TENS: w_digit = score_tens;
            default:        w_digit = w_cap_ones;
        endcase
    end

    bcd_to_seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    // Next output word: anode one-hot-low, blanking and pause separator
    always_comb begin
        w_an_nxt  = ~(4'b0001 << r_digit_sel);
        w_seg_nxt = w_dec_seg;
        w_dp_nxt  = ~((r_digit_sel == DIG_SCORE_ONES) && pause);
`ifdef TIMER_DISPLAY_LZ_BLANK_EN
        if ((r_digit_sel == DIG_SCORE_TENS) && (score_tens == 4'd0)) begin
            w_seg_nxt = SEG_BLANK;
        end
        if ((r_digit_sel == DIG_SEC_TENS) && (w_cap_tens == 4'd0)) begin
            w_seg_nxt = SEG_BLANK;
        end
`endif
        // Timer slots go fully dark in the off half of the blink
        if (((r_digit_sel == DIG_SEC_ONES) || (r_digit_sel == DIG_SEC_TENS)) && !r_blink_on) begin
            w_an_nxt  = 4'b1111;
            w_seg_nxt = SEG_BLANK;
        end
    end

    // Registered outputs so anode, segments and dp switch together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_timer_display.sv
// Directed testbench for timer_display with REFRESH_DIV=4, BLINK_DIV=8.
module tb_timer_display;

    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_3     = 7'b0110000;
    localparam logic [6:0] S_6     = 7'b0000010;
    localparam logic [6:0] S_7     = 7'b1111000;
    localparam logic [6:0] S_9     = 7'b0010000;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sec_tens = 4'd0;
    logic [3:0] sec_ones = 4'd0;
    logic       end_game = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] score_tens = 4'd0;
    logic [3:0] score_ones = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int errors = 0;
    int checks = 0;

    timer_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .end_game   (end_game),
        .pause      (pause),
        .score_tens (score_tens),
        .score_ones (score_ones),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    // Reset for 5 cycles and release on a falling edge; next rising edge is k=1
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        sec_tens = 4'd6; sec_ones = 4'd0; score_tens = 4'd3; score_ones = 4'd7;
        end_game = 1'b0; pause = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++;
        if (seg !== S_BLANK) begin errors++; $display("FAIL reset_seg got=%b exp=%b", seg, S_BLANK); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL first_slot_an got=%b exp=1110", an); end
        checks++;
        if (seg !== S_0) begin errors++; $display("FAIL first_slot_seg got=%b exp=%b", seg, S_0); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int sel;
        sec_tens = 4'd6; sec_ones = 4'd0; score_tens = 4'd3; score_ones = 4'd7;
        end_game = 1'b0; pause = 1'b0;
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            sel = ((k - 1) / 4) % 4;
            case (sel)
                0: begin exp_an = 4'b1110; exp_seg = S_0; end
                1: begin exp_an = 4'b1101; exp_seg = S_6; end
                2: begin exp_an = 4'b1011; exp_seg = S_7; end
                default: begin exp_an = 4'b0111; exp_seg = S_3; end
            endcase
            checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
                errors++;
                $display("FAIL scan k=%0d got an=%b seg=%b dp=%b exp an=%b seg=%b dp=1",
                         k, an, seg, dp, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_reset_midscan();
        sec_tens = 4'd6; sec_ones = 4'd0; score_tens = 4'd3; score_ones = 4'd7;
        do_reset();
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== S_BLANK || dp !== 1'b1) begin
            errors++;
            $display("FAIL midscan_reset got an=%b seg=%b dp=%b exp an=1111 seg=%b dp=1", an, seg, dp, S_BLANK);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL midscan_restart_an got=%b exp=1110", an); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1101) begin errors++; $display("FAIL midscan_second_slot got=%b exp=1101", an); end
    endtask

    task automatic test_cdc_update();
        bit seen_new;
        sec_tens = 4'd6; sec_ones = 4'd0; score_tens = 4'd3; score_ones = 4'd7;
        do_reset();
        repeat (14) @(posedge clk);
        #3;
        sec_ones = 4'd9;
        seen_new = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (an === 4'b1110) begin
                checks++;
                if (c <= 3 && seg !== S_0) begin
                    errors++;
                    $display("FAIL cdc_early c=%0d got seg=%b exp=%b", c, seg, S_0);
                end else if (seg !== S_0 && seg !== S_9) begin
                    errors++;
                    $display("FAIL cdc_torn c=%0d got seg=%b exp=%b or %b", c, seg, S_0, S_9);
                end
                if (seg === S_9) seen_new = 1'b1;
            end
        end
        checks++;
        if (!seen_new) begin errors++; $display("FAIL cdc_timeout got no seg=%b within 40 cycles", S_9); end
        @(negedge clk);
        sec_ones = 4'd0;
    endtask

    task automatic test_blink();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int sel;
        bit dark;
        sec_tens = 4'd6; sec_ones = 4'd0; score_tens = 4'd3; score_ones = 4'd7;
        pause = 1'b0;
        end_game = 1'b1;
        do_reset();
        // end_game is captured at k=3; blink restarts visible at k=4, first dark
        // output at k=13, then 8 output cycles dark / 8 lit.
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            sel = ((k - 1) / 4) % 4;
            dark = (sel < 2) && (k >= 13) && (((k - 13) % 16) < 8);
            case (sel)
                0: begin exp_an = 4'b1110; exp_seg = S_0; end
                1: begin exp_an = 4'b1101; exp_seg = S_6; end
                2: begin exp_an = 4'b1011; exp_seg = S_7; end
                default: begin exp_an = 4'b0111; exp_seg = S_3; end
            endcase
            if (dark) begin exp_an = 4'b1111; exp_seg = S_BLANK; end
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL blink k=%0d got an=%b seg=%b exp an=%b seg=%b", k, an, seg, exp_an, exp_seg);
            end
        end
        @(negedge clk);
        end_game = 1'b0;
    endtask

    task automatic test_invalid_pause();
        bit found;
        sec_tens = 4'd6; sec_ones = 4'd0; score_tens = 4'd3; score_ones = 4'd7;
        do_reset();
        @(negedge clk);
        score_ones = 4'd12;
        pause = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (an === 4'b1011) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL invalid_wait got no an=1011 slot within 40 cycles");
        end else begin
            checks++;
            if (seg !== S_DASH) begin errors++; $display("FAIL invalid_seg got=%b exp=%b", seg, S_DASH); end
            checks++;
            if (dp !== 1'b0) begin errors++; $display("FAIL pause_dp got=%b exp=0", dp); end
        end
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (an === 4'b0111) found = 1'b1;
        end
        checks++;
        if (!found || dp !== 1'b1) begin
            errors++;
            $display("FAIL pause_dp_other_slot got found=%0d dp=%b exp found=1 dp=1", found, dp);
        end
        @(negedge clk);
        score_ones = 4'd7;
        pause = 1'b0;
    endtask

    task automatic test_leading_zero();
        bit found;
        logic [6:0] exp_seg;
`ifdef TIMER_DISPLAY_LZ_BLANK_EN
        exp_seg = S_BLANK;
`else
        exp_seg = S_0;
`endif
        sec_tens = 4'd6; sec_ones = 4'd0; score_tens = 4'd3; score_ones = 4'd7;
        do_reset();
        repeat (6) @(posedge clk);
        @(negedge clk);
        sec_tens = 4'd0;
        repeat (6) @(posedge clk);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            if (an === 4'b1101) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL lz_wait got no an=1101 slot within 40 cycles");
        end else begin
            checks++;
            if (seg !== exp_seg) begin errors++; $display("FAIL lz_sec_tens got=%b exp=%b", seg, exp_seg); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_reset_midscan();
        test_cdc_update();
        test_blink();
        test_invalid_pause();
        test_leading_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
